// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus controllers (read and write side).
package lcd_pkg;

    // Bus-cycle phases shared by the LCD cycle engines.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EN_HI = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } lcd_state_e;

    // Default bus timing in iCLK cycles, common to the read and write controllers.
    localparam int unsigned DEF_CLK_DIVIDE = 16;
    localparam int unsigned DEF_SETUP_CYC  = 2;
    localparam int unsigned DEF_HOLD_CYC   = 2;
    localparam int unsigned DEF_MAX_POLLS  = 1000;

    // Busy flag position in the status byte returned by an RS=0 read.
    localparam int unsigned LCD_BF_BIT = 7;

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase timer: 8-bit up-counter with synchronous clear; hit flags the terminal count.
module lcd_phase_timer (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       clr,
    input  logic [7:0] limit,
    output logic       hit
);

    logic [7:0] cnt;

    // Count cycles spent in the current phase; cleared whenever the phase changes.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else
            cnt <= cnt + 8'd1;
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/lcd_read_controller.sv
// Read-cycle engine for the HD44780-style LCD bus. One read per rising edge of iStart.
// Optional feature: define LCD_BUSY_POLL_EN to repeat RS=0 reads while the busy flag is set
// (bounded by MAX_POLLS, reported on oTimeout).
module lcd_read_controller
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_Divide = DEF_CLK_DIVIDE,
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned MAX_POLLS  = DEF_MAX_POLLS
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iRS,
    input  logic       iStart,
    output logic [7:0] oDATA,
    output logic       oDone,
    output logic       oBusy,
`ifdef LCD_BUSY_POLL_EN
    output logic       oTimeout,
`endif
    input  logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    // Elaboration-time guard on the legal parameter ranges.
    if (CLK_Divide < 1 || CLK_Divide > 255 ||
        SETUP_CYC  < 1 || SETUP_CYC  > 255 ||
        HOLD_CYC   < 1 || HOLD_CYC   > 255 ||
        MAX_POLLS  < 1 || MAX_POLLS  > 65535) begin : g_param_check
        $error("lcd_read_controller: parameter out of range");
    end

    lcd_state_e state, state_next;

    logic       pre_start;
    logic       start_edge;
    logic       accept;
    logic       rs_q;
    logic [7:0] data_q;
    logic       sample;
    logic       timer_clr;
    logic [7:0] timer_limit;
    logic       timer_hit;

`ifdef LCD_BUSY_POLL_EN
    logic [15:0] poll_cnt;
    logic        poll_again;
    logic        poll_timeout;
    logic        timeout_q;
`endif

    // A request is a 0->1 transition; only honoured when no read is in flight.
    assign start_edge = iStart & ~pre_start;
    assign accept     = start_edge && (state == IDLE || state == DONE);

    // Register iStart for edge detection; a held-high request yields one read only.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            pre_start <= 1'b0;
        else
            pre_start <= iStart;
    end

    // Phase state register; reset drops RW/EN at once since both decode from state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-phase decision, sample strobe and timer control.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        poll_again   = 1'b0;
        poll_timeout = 1'b0;
`endif
        case (state)
            IDLE, DONE: if (start_edge) state_next = SETUP;
            SETUP:      if (timer_hit)  state_next = EN_HI;
            EN_HI: begin
                if (timer_hit) begin
                    state_next = HOLD;
                    sample     = 1'b1;
                end
            end
            HOLD: begin
                if (timer_hit) begin
                    state_next = DONE;
`ifdef LCD_BUSY_POLL_EN
                    // Status read still busy: re-read unless the poll budget is spent.
                    if (!rs_q && data_q[LCD_BF_BIT]) begin
                        if (poll_cnt == 16'(MAX_POLLS - 1)) begin
                            poll_timeout = 1'b1;
                        end else begin
                            state_next = SETUP;
                            poll_again = 1'b1;
                        end
                    end
`endif
                end
            end
            default: state_next = IDLE;
        endcase
        timer_clr = (state_next != state) || (state == IDLE) || (state == DONE);
    end

    // Terminal count for the current phase (parameter - 1).
    always_comb begin
        timer_limit = 8'd0;
        case (state)
            SETUP:   timer_limit = 8'(SETUP_CYC - 1);
            EN_HI:   timer_limit = 8'(CLK_Divide - 1);
            HOLD:    timer_limit = 8'(HOLD_CYC - 1);
            default: timer_limit = 8'd0;
        endcase
    end

    lcd_phase_timer u_timer (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .clr    (timer_clr),
        .limit  (timer_limit),
        .hit    (timer_hit)
    );

    // Latch register select at request acceptance; it stays put for the whole read.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            rs_q <= 1'b0;
        else if (accept)
            rs_q <= iRS;
    end

    // Capture the bus on the edge that ends the enable pulse; hold otherwise.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            data_q <= '0;
        else if (sample)
            data_q <= LCD_DATA;
    end

`ifdef LCD_BUSY_POLL_EN
    // Count busy re-reads within one request and flag exhaustion of the poll budget.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            poll_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            poll_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (poll_again)
                poll_cnt <= poll_cnt + 16'd1;
            if (poll_timeout)
                timeout_q <= 1'b1;
        end
    end

    assign oTimeout = timeout_q;
`endif

    assign LCD_RW = (state == SETUP) || (state == EN_HI) || (state == HOLD);
    assign LCD_EN = (state == EN_HI);
    assign LCD_RS = rs_q;
    assign oBusy  = LCD_RW;
    assign oDone  = (state == DONE);
    assign oDATA  = data_q;

endmodule

// File: doc/lcd_read_controller.md
# lcd_read_controller

Read-cycle engine for the HD44780-style character LCD bus: the read-side counterpart of the team's write-only LCD controller. On a rising edge of `iStart` it runs one read cycle with `LCD_RW` high. A read with RS=0 returns the busy flag and address counter; a read with RS=1 returns DDRAM/CGRAM data. It returns the sampled byte to the host with a level `oDone`. It sits beside the write controller under the LCD top level; the top level gives this block ownership of the data bus whenever `LCD_RW`=1.

## Interface
Parameters:
- `CLK_Divide`, 16: number of iCLK cycles that `LCD_EN` is held high; legal range 1..255.
- `SETUP_CYC`, 2: cycles that RS/RW are stable before `LCD_EN` rises; legal range 1..255.
- `HOLD_CYC`, 2: cycles that RS/RW are held after `LCD_EN` falls; legal range 1..255.
- `MAX_POLLS`, 1000: busy-poll limit, 16-bit; used only with `LCD_BUSY_POLL_EN`.

Ports:
- `iCLK` in 1: clock.
- `iRST_N` in 1: reset, asynchronous, active-low.
- `iRS` in 1: register select for the requested read; latched at the start edge.
- `iStart` in 1: request; a 0→1 transition starts a read.
- `oDATA` out 8: last sampled byte.
- `oDone` out 1: level; high when a read has completed, low while a read is in progress.
- `oBusy` out 1: high while a read cycle is in progress.
- `oTimeout` out 1: present only with `LCD_BUSY_POLL_EN`; high when busy polling hit `MAX_POLLS`.
- `LCD_DATA` in 8: LCD data bus, input only; the top level disables the writer's drivers when `LCD_RW`=1.
- `LCD_RW` out 1: high during a read cycle.
- `LCD_EN` out 1: enable strobe.
- `LCD_RS` out 1: latched RS.

## Operation
- Reset values: all outputs 0, state IDLE, counter 0, `preStart` 0.
- Start detect: `preStart` registers `iStart` every cycle. An edge is `{preStart, iStart}` = 01.
  - In IDLE or DONE, an edge latches `iRS`, clears `oDone` and `oTimeout`, sets `oBusy`, and moves to SETUP.
  - An edge in any other state is ignored. It is not queued.
- States:
  - IDLE: `LCD_RW`=0, `LCD_EN`=0.
  - SETUP: `LCD_RW`=1, `LCD_RS`=latched RS, `LCD_EN`=0. Stays for `SETUP_CYC` cycles, then goes to EN_HI.
  - EN_HI: `LCD_EN`=1 for `CLK_Divide` cycles. On the clock edge that ends EN_HI, `LCD_DATA` is captured into `oDATA` and `LCD_EN` drops. Next state is HOLD.
  - HOLD: `LCD_EN`=0, RW and RS unchanged, for `HOLD_CYC` cycles. Then goes to DONE (or back to SETUP, see Configuration).
  - DONE: `LCD_RW`=0, `oDone`=1, `oBusy`=0. Remains until the next start edge.
- Counter: 8 bits, cleared on every state change. Each state exits when counter equals its parameter − 1.
- `oDATA` changes only at the sample edge and holds its value otherwise.
- Reset mid-cycle: immediate return to IDLE. `LCD_EN` and `LCD_RW` go low asynchronously. `oDATA` is cleared and no partial read is reported.
- `iStart` held high produces exactly one read.

## Timing
- Edge detected at clock edge E, with default parameters:
  - `LCD_RW` and `oBusy` high from E.
  - `LCD_EN` high from E+2 to E+18.
  - Sample at E+18.
  - `oDone` rises and `LCD_RW` falls at E+20.
- Latency from E to `oDone` = `SETUP_CYC` + `CLK_Divide` + `HOLD_CYC`.
- RS and RW never change while `LCD_EN` is high.
- Minimum spacing between back-to-back reads: one cycle in DONE, plus the low half of `iStart`.

## Configuration
- `LCD_BUSY_POLL_EN` defined:
  - A read with latched RS=0 whose sampled bit 7 is 1 goes from HOLD back to SETUP and increments a 16-bit poll counter. It does not go to DONE.
  - A sample with bit 7 = 0 ends in DONE.
  - When the poll counter reaches `MAX_POLLS`, the block goes to DONE with `oTimeout`=1.
  - `oDATA` always holds the last sample.
  - Reads with RS=1 are never repeated.
- `LCD_BUSY_POLL_EN` undefined: every request performs exactly one read cycle. The `oTimeout` port and the poll counter do not exist.

## Structure
- Shared package `lcd_pkg` holds:
  - the state enum (IDLE, SETUP, EN_HI, HOLD, DONE);
  - default timing constants, also used by the write controller;
  - `LCD_BF_BIT` = 7.
- One sub-module, `lcd_phase_timer`: 8-bit counter with clear input and compare-to-limit output, instantiated once.

## Test plan
- Reset, then one RS=1 read with `LCD_DATA`=0x5A → `LCD_EN` high for exactly 16 cycles; `oDATA`=0x5A; `oDone` rises 20 cycles after the edge; `LCD_RW` high for exactly 20 cycles.
- `LCD_DATA` changes from 0x11 to 0x22 one cycle before the sample edge → `oDATA`=0x22; RS and RW stable throughout `LCD_EN` high.
- `iStart` re-pulsed during EN_HI, then held high for 100 cycles → exactly one `LCD_EN` pulse; `oDone` stays high afterwards.
- `iRST_N` asserted in the 5th cycle of EN_HI → `LCD_EN`, `LCD_RW`, `oDATA` and `oDone` all 0 immediately; the next start produces a normal read.
- Poll build: RS=0 with `LCD_DATA`=0x80 for 3 reads, then 0x05 → 4 `LCD_EN` pulses; `oDATA`=0x05; `oTimeout`=0.
- Poll build with `MAX_POLLS`=4 and `LCD_DATA` stuck at 0xFF → 4 pulses, then `oDone`=1 and `oTimeout`=1.
